mem_stage: RTL and testbench

Memory/writeback stage that consumes the `alu_signals` bundle registered by the execute stage. It performs the requested byte or word load/store over an 8-bit memory bus with a ready handshake, sequencing word accesses as two byte transfers, little-endian. It then drives register-file and PC writeback. It sits between execute and the register file/PC, and reports `busy` to the control unit so the pipeline holds during memory wait states.

---
 rtl/mem_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory/writeback stage: byte/word load-store over an 8-bit ready-handshake bus, then RF/PC writeback.
// Optional transfer timeout with bus_err is compiled in by defining MEM_STAGE_TIMEOUT_EN.

package mem_stage_pkg;
   typedef struct packed {
      logic [15:0] data_out;
      logic [1:0]  reg_write;
      logic [3:0]  reg_dest;
      logic        setPC;
      logic [1:0]  mem_read;
      logic [1:0]  mem_write;
      logic [15:0] mem_addr;
   } alu_signals;
endpackage

module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  alu_signals  control_signals_in,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_req,
   output logic        mem_we,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready,
   output logic [1:0]  rf_we,
   output logic [3:0]  rf_dest,
   output logic [15:0] rf_data,
   output logic        pc_we,
   output logic [15:0] pc_data,
   output logic        busy,
   output logic        done,
   output logic        bus_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_LO,
      S_RD_HI,
      S_WR_LO,
      S_WR_HI,
      S_WB
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_data;
   logic [1:0]  r_regWrite;
   logic [3:0]  r_regDest;
   logic        r_setPc;
   logic [15:0] r_addr;
   logic        r_isLoad;
   logic        r_isWord;
   logic [7:0]  r_lo;
   logic [7:0]  r_hi;
   logic        w_accept;
   logic        w_inReq;
   logic        w_timeout;

   assign w_accept = (r_state == S_IDLE) && en;
   assign w_inReq  = (r_state == S_RD_LO) || (r_state == S_RD_HI) ||
                     (r_state == S_WR_LO) || (r_state == S_WR_HI);

`ifdef MEM_STAGE_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] r_waitCnt;
   logic            r_busErr;

   assign w_timeout = w_inReq && !mem_ready &&
                      (r_waitCnt == CntW'(TIMEOUT_CYCLES - 1));

   // Counter restarts on every state change, so each byte transfer gets its own budget
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_waitCnt <= '0;
         r_busErr  <= 1'b0;
      end else begin
         r_busErr <= w_timeout;
         if ((w_next != r_state) || !w_inReq)
            r_waitCnt <= '0;
         else
            r_waitCnt <= r_waitCnt + 1'b1;
      end
   end

   assign bus_err = r_busErr;
`else
   assign w_timeout = 1'b0;
   assign bus_err   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Write wins over read when both are requested
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (en) begin
               if (control_signals_in.mem_write[0])
                  w_next = S_WR_LO;
               else if (control_signals_in.mem_read[0])
                  w_next = S_RD_LO;
               else
                  w_next = S_WB;
            end
         end
         S_RD_LO: begin
            if (w_timeout)
               w_next = S_IDLE;
            else if (mem_ready)
               w_next = r_isWord ? S_RD_HI : S_WB;
         end
         S_WR_LO: begin
            if (w_timeout)
               w_next = S_IDLE;
            else if (mem_ready)
               w_next = r_isWord ? S_WR_HI : S_WB;
         end
         S_RD_HI, S_WR_HI: begin
            if (w_timeout)
               w_next = S_IDLE;
            else if (mem_ready)
               w_next = S_WB;
         end
         S_WB:    w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_data     <= '0;
         r_regWrite <= '0;
         r_regDest  <= '0;
         r_setPc    <= 1'b0;
         r_addr     <= '0;
         r_isLoad   <= 1'b0;
         r_isWord   <= 1'b0;
         r_lo       <= '0;
         r_hi       <= '0;
      end else begin
         if (w_accept) begin
            r_data     <= control_signals_in.data_out;
            r_regWrite <= control_signals_in.reg_write;
            r_regDest  <= control_signals_in.reg_dest;
            r_setPc    <= control_signals_in.setPC;
            r_addr     <= control_signals_in.mem_addr;
            r_isLoad   <= !control_signals_in.mem_write[0] && control_signals_in.mem_read[0];
            r_isWord   <= control_signals_in.mem_write[0] ? control_signals_in.mem_write[1]
                                                          : control_signals_in.mem_read[1];
            r_lo       <= '0;
            r_hi       <= '0;
         end
         if ((r_state == S_RD_LO) && mem_ready)
            r_lo <= mem_rdata;
         if ((r_state == S_RD_HI) && mem_ready)
            r_hi <= mem_rdata;
      end
   end

   // Outputs decode registered state only, keeping mem_ready off every output path
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      rf_we     = '0;
      rf_dest   = '0;
      rf_data   = '0;
      pc_we     = 1'b0;
      pc_data   = '0;
      unique case (r_state)
         S_RD_LO: begin
            mem_req  = 1'b1;
            mem_addr = r_addr;
         end
         S_RD_HI: begin
            mem_req  = 1'b1;
            mem_addr = r_addr + 16'd1;
         end
         S_WR_LO: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_addr;
            mem_wdata = r_data[7:0];
         end
         S_WR_HI: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_addr + 16'd1;
            mem_wdata = r_data[15:8];
         end
         S_WB: begin
            rf_we   = r_regWrite;
            rf_dest = r_regDest;
            if (r_isLoad)
               rf_data = r_isWord ? {r_hi, r_lo} : {8'h00, r_lo};
            else
               rf_data = r_data;
            pc_we   = r_setPc;
            pc_data = r_data;
         end
         default: ;
      endcase
   end

   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_WB);

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard queues for bus transfers and writebacks.
// Timeout scenario runs only when MEM_STAGE_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module tb_mem_stage;
   import mem_stage_pkg::*;

   typedef struct {
      logic [1:0]  we;
      logic [3:0]  dest;
      logic [15:0] data;
      logic        pcWe;
      logic [15:0] pcData;
      int          cyc;
   } wbExp_t;

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic [7:0]  data;
   } busExp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   alu_signals  control_signals_in;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_req;
   logic        mem_we;
   logic [7:0]  mem_rdata;
   logic        mem_ready;
   logic [1:0]  rf_we;
   logic [3:0]  rf_dest;
   logic [15:0] rf_data;
   logic        pc_we;
   logic [15:0] pc_data;
   logic        busy;
   logic        done;
   logic        bus_err;

   logic [7:0]  tbMem [0:65535];
   wbExp_t      wbQ[$];
   busExp_t     busQ[$];
   wbExp_t      monE;
   int          cycleCnt = 0;
   int          reqCycles = 0;
   int          testsRun = 0;
   int          testsFailed = 0;

   mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .control_signals_in(control_signals_in),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .rf_we(rf_we), .rf_dest(rf_dest),
      .rf_data(rf_data), .pc_we(pc_we), .pc_data(pc_data), .busy(busy), .done(done),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   assign mem_rdata = tbMem[mem_addr];

   // Monitor: bus transfers and writebacks are checked against the scoreboard queues
   always @(negedge clk) begin
      if (mem_req) begin
         reqCycles++;
         testsRun++;
         if (busQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL bus_unexpected: mem_req=1 addr=%h we=%b, required no request", mem_addr, mem_we);
         end else if (mem_addr !== busQ[0].addr || mem_we !== busQ[0].we ||
                      (busQ[0].we && mem_wdata !== busQ[0].data)) begin
            testsFailed++;
            $display("[TB] FAIL bus_xfer: got addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                     mem_addr, mem_we, mem_wdata, busQ[0].addr, busQ[0].we, busQ[0].data);
         end
         if (mem_ready && busQ.size() != 0) begin
            if (mem_we) tbMem[mem_addr] = mem_wdata;
            busQ.delete(0);
         end
      end
      if (done) begin
         testsRun++;
         if (wbQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL wb_unexpected: done=1 rf_we=%b rf_data=%h, required no writeback", rf_we, rf_data);
         end else begin
            monE = wbQ.pop_front();
            if ({rf_we, rf_dest, rf_data, pc_we, pc_data} !==
                {monE.we, monE.dest, monE.data, monE.pcWe, monE.pcData}) begin
               testsFailed++;
               $display("[TB] FAIL wb_value: got we=%b dest=%0d data=%h pc_we=%b pc=%h, required we=%b dest=%0d data=%h pc_we=%b pc=%h",
                        rf_we, rf_dest, rf_data, pc_we, pc_data,
                        monE.we, monE.dest, monE.data, monE.pcWe, monE.pcData);
            end
            testsRun++;
            if (cycleCnt != monE.cyc) begin
               testsFailed++;
               $display("[TB] FAIL wb_latency: got cycle %0d, required cycle %0d", cycleCnt, monE.cyc);
            end
         end
      end else begin
         testsRun++;
         if (rf_we !== 2'b00 || pc_we !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL wb_outside: got rf_we=%b pc_we=%b without done, required 00/0", rf_we, pc_we);
         end
      end
`ifndef MEM_STAGE_TIMEOUT_EN
      testsRun++;
      if (bus_err !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL bus_err_tied: got %b, required 0", bus_err);
      end
`endif
   end

   task automatic doOp(input alu_signals c, input int nXfer, input int w0,
                       input logic noisyEn, input wbExp_t e);
      alu_signals junk;
      junk = '0;
      junk.data_out  = 16'hDEAD;
      junk.reg_write = 2'b11;
      junk.reg_dest  = 4'hF;
      e.cyc = cycleCnt + 1 + nXfer + w0;
      wbQ.push_back(e);
      control_signals_in = c;
      en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      for (int x = 0; x < nXfer; x++) begin
         if (x == 0) begin
            for (int k = 0; k < w0; k++) begin
               mem_ready = 1'b0;
               if (noisyEn) begin
                  control_signals_in = junk;
                  en = 1'b1;
               end
               @(posedge clk); #1;
            end
         end
         mem_ready = 1'b1;
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      en = 1'b0;
   endtask

   task automatic waitIdle(input string name);
      int k;
      k = 0;
      while (busy && k < 30) begin
         @(posedge clk); #1;
         k++;
      end
      testsRun++;
      if (busy) begin
         testsFailed++;
         $display("[TB] FAIL %s_idle: busy=%b after 30 cycles, required 0", name, busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      testsRun++;
      if ({mem_req, mem_we, rf_we, pc_we, busy, done, bus_err,
           mem_addr, mem_wdata, rf_data, rf_dest, pc_data} !== '0) begin
         testsFailed++;
         $display("[TB] FAIL reset_outputs: req=%b we=%b rf_we=%b pc_we=%b busy=%b done=%b err=%b addr=%h wd=%h rd=%h dst=%h pc=%h, required all 0",
                  mem_req, mem_we, rf_we, pc_we, busy, done, bus_err,
                  mem_addr, mem_wdata, rf_data, rf_dest, pc_data);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_nonmem;
      alu_signals c;
      wbExp_t e;
      c = '0;
      c.data_out  = 16'h1234;
      c.reg_write = 2'b11;
      c.reg_dest  = 4'd3;
      e = '{we: 2'b11, dest: 4'd3, data: 16'h1234, pcWe: 1'b0, pcData: 16'h1234, cyc: 0};
      doOp(c, 0, 0, 1'b0, e);
      waitIdle("nonmem");
   endtask

   task automatic test_word_load;
      alu_signals c;
      wbExp_t e;
      tbMem[16'h00FE] = 8'hCD;
      tbMem[16'h00FF] = 8'hAB;
      c = '0;
      c.reg_write = 2'b11;
      c.reg_dest  = 4'd5;
      c.mem_read  = 2'b11;
      c.mem_addr  = 16'h00FE;
      busQ.push_back('{addr: 16'h00FE, we: 1'b0, data: 8'h00});
      busQ.push_back('{addr: 16'h00FF, we: 1'b0, data: 8'h00});
      e = '{we: 2'b11, dest: 4'd5, data: 16'hABCD, pcWe: 1'b0, pcData: 16'h0000, cyc: 0};
      doOp(c, 2, 0, 1'b0, e);
      waitIdle("word_load");
   endtask

   task automatic test_word_store;
      alu_signals c;
      wbExp_t e;
      c = '0;
      c.data_out  = 16'hBEEF;
      c.mem_write = 2'b11;
      c.mem_addr  = 16'hFFFF;
      busQ.push_back('{addr: 16'hFFFF, we: 1'b1, data: 8'hEF});
      busQ.push_back('{addr: 16'h0000, we: 1'b1, data: 8'hBE});
      e = '{we: 2'b00, dest: 4'd0, data: 16'hBEEF, pcWe: 1'b0, pcData: 16'hBEEF, cyc: 0};
      reqCycles = 0;
      doOp(c, 2, 2, 1'b0, e);
      waitIdle("word_store");
      testsRun++;
      if (reqCycles != 4) begin
         testsFailed++;
         $display("[TB] FAIL word_store_req_cycles: got %0d, required 4", reqCycles);
      end
   endtask

   task automatic test_byte_load_busy_en;
      alu_signals c;
      wbExp_t e;
      tbMem[16'h0010] = 8'h80;
      tbMem[16'h0011] = 8'h7E;
      c = '0;
      c.data_out  = 16'h5555;
      c.reg_write = 2'b01;
      c.reg_dest  = 4'd7;
      c.mem_read  = 2'b01;
      c.mem_addr  = 16'h0010;
      busQ.push_back('{addr: 16'h0010, we: 1'b0, data: 8'h00});
      e = '{we: 2'b01, dest: 4'd7, data: 16'h0080, pcWe: 1'b0, pcData: 16'h5555, cyc: 0};
      doOp(c, 1, 2, 1'b1, e);
      waitIdle("byte_load");
   endtask

   task automatic test_store_priority_pc;
      alu_signals c;
      wbExp_t e;
      c = '0;
      c.data_out  = 16'h0400;
      c.setPC     = 1'b1;
      c.mem_read  = 2'b01;
      c.mem_write = 2'b01;
      c.mem_addr  = 16'h0300;
      busQ.push_back('{addr: 16'h0300, we: 1'b1, data: 8'h00});
      e = '{we: 2'b00, dest: 4'd0, data: 16'h0400, pcWe: 1'b1, pcData: 16'h0400, cyc: 0};
      doOp(c, 1, 0, 1'b0, e);
      waitIdle("store_pc");
   endtask

   task automatic test_reset_abort;
      alu_signals c;
      c = '0;
      c.reg_write = 2'b01;
      c.mem_read  = 2'b01;
      c.mem_addr  = 16'h0020;
      busQ.push_back('{addr: 16'h0020, we: 1'b0, data: 8'h00});
      control_signals_in = c;
      en = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk); #1;
      en = 1'b0;
      testsRun++;
      if (mem_req !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL abort_req_before: got mem_req=%b, required 1", mem_req);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      testsRun++;
      if ({mem_req, busy, done} !== 3'b000) begin
         testsFailed++;
         $display("[TB] FAIL abort_after_reset: got req=%b busy=%b done=%b, required 000", mem_req, busy, done);
      end
      rst_n = 1'b1;
      busQ.delete();
      repeat (3) @(posedge clk);
      #1;
   endtask

`ifdef MEM_STAGE_TIMEOUT_EN
   task automatic test_timeout;
      alu_signals c;
      int reqCnt;
      logic errSeen;
      c = '0;
      c.reg_write = 2'b11;
      c.mem_read  = 2'b11;
      c.mem_addr  = 16'h0040;
      busQ.push_back('{addr: 16'h0040, we: 1'b0, data: 8'h00});
      control_signals_in = c;
      mem_ready = 1'b0;
      en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      reqCnt = 0;
      errSeen = 1'b0;
      for (int k = 0; k < 20 && !errSeen; k++) begin
         if (mem_req) reqCnt++;
         if (bus_err) errSeen = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      testsRun++;
      if (!errSeen || reqCnt != 4 || busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL timeout: got bus_err_seen=%b req_cycles=%0d busy=%b, required 1/4/0", errSeen, reqCnt, busy);
      end
      busQ.delete();
      @(posedge clk); #1;
      testsRun++;
      if (bus_err !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL timeout_pulse: got bus_err=%b one cycle later, required 0", bus_err);
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      en = 1'b0;
      mem_ready = 1'b0;
      control_signals_in = '0;
      for (int i = 0; i < 65536; i++) tbMem[i] = 8'h00;
      @(posedge clk); #1;
      test_reset;
      test_nonmem;
      test_word_load;
      test_word_store;
      test_byte_load_busy_en;
      test_store_priority_pc;
      test_reset_abort;
`ifdef MEM_STAGE_TIMEOUT_EN
      test_timeout;
`endif
      testsRun++;
      if (wbQ.size() != 0 || busQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL queues_drained: got wb=%0d bus=%0d pending, required 0/0", wbQ.size(), busQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
